writeback_stage: RTL

- MEM/WB pipeline register and write-back logic for the RV32I 5-stage pipeline.
- Captures memory-stage results on the rising edge and extracts/extends load data.
- Selects the final result and drives the register-file write port (RdW, ResultW, RegWriteW), which the register file commits on the following falling edge.
- Also supplies the W-stage forwarding source to the hazard unit and guards x0 against writes.

---
 rtl/writeback_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back result selection for the RV32I pipeline.
// Optional retired-instruction counter enabled with `define WB_RETIRE_COUNT_EN.
module writeback_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic            StallW,
  input  logic            FlushW,
  output logic [XLEN-1:0] ResultW,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic            ValidW
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]     InstRetW
`endif
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
  } wb_reg_t;

  wb_reg_t w_d;
  wb_reg_t w_q;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    w_d            = '0;
    w_d.valid      = ValidM;
    w_d.reg_write  = RegWriteM;
    w_d.result_src = ResultSrcM;
    w_d.funct3     = Funct3M;
    w_d.rd         = RdM;
    w_d.alu_result = ALUResultM;
    w_d.read_data  = ReadDataM;
    w_d.pc_plus4   = PCPlus4M;
  end

  // W register: flush beats stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q <= '0;
    end else if (FlushW) begin
      w_q <= '0;
    end else if (!StallW) begin
      w_q <= w_d;
    end
  end

  // Byte/half lanes picked straight from the offset to keep the path short
  always_comb begin
    ld_byte = 8'h00;
    case (w_q.alu_result[1:0])
      2'b00:   ld_byte = w_q.read_data[7:0];
      2'b01:   ld_byte = w_q.read_data[15:8];
      2'b10:   ld_byte = w_q.read_data[23:16];
      default: ld_byte = w_q.read_data[31:24];
    endcase
    ld_half = w_q.alu_result[1] ? w_q.read_data[31:16] : w_q.read_data[15:0];
  end

  always_comb begin
    ld_data = w_q.read_data;
    case (w_q.funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = w_q.read_data;
    endcase
  end

  always_comb begin
    ResultW = w_q.alu_result;
    case (w_q.result_src)
      2'b01:   ResultW = ld_data;
      2'b10:   ResultW = w_q.pc_plus4;
      default: ResultW = w_q.alu_result;
    endcase
  end

  // x0 is never written anywhere else in the pipeline
  assign RegWriteW = w_q.reg_write & w_q.valid & (w_q.rd != 5'd0);
  assign RdW       = w_q.rd;
  assign ValidW    = w_q.valid;

`ifdef WB_RETIRE_COUNT_EN
  localparam int unsigned CNT_W = 64;

  logic [CNT_W-1:0] inst_ret_q;

  // Counts the held instruction as retired when it leaves W; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_ret_q <= '0;
    end else if (w_q.valid && !StallW) begin
      inst_ret_q <= inst_ret_q + CNT_W'(1);
    end
  end

  assign InstRetW = inst_ret_q;
`endif

endmodule
